// File: rtl/debounce_pkg.sv
// Shared types and default constants for the push-button debouncer and its
// companion time-counter stage.
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE_LOW   = 2'd0,
        CHECK_HIGH = 2'd1,
        IDLE_HIGH  = 2'd2,
        CHECK_LOW  = 2'd3
    } fsm_state_t;

    localparam int DEFAULT_CNT_W       = 6;
    localparam int DEFAULT_STABLE_CNT  = 50;
    localparam int DEFAULT_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser that brings the asynchronous button level into the
// clk domain; all flops clear to 0 on reset.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // NOTE: clocked state is written with <= so every flop samples the pre-edge value of its neighbour.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/debounce_fsm.sv
// Control stage of the push-button debouncer: synchronises the raw button, runs the
// stability FSM, steers the external time counter and emits a clean level plus pulses.
module debounce_fsm
    import debounce_pkg::*;
#(
    parameter int CNT_W       = DEFAULT_CNT_W,
    parameter int STABLE_CNT  = DEFAULT_STABLE_CNT,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             button_raw,
    input  logic [CNT_W-1:0] time_counter,
    output logic             state,
    output logic             count_finished,
    output logic             button_db,
    output logic             button_press,
    output logic             button_release
);

    localparam logic [CNT_W-1:0] THRESHOLD = CNT_W'(STABLE_CNT - 1);

    logic       sync_in;
    fsm_state_t fsm_state;
    fsm_state_t next_state;

    sync_ff #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (button_raw),
        .q    (sync_in)
    );

    // Pulses and level change only on threshold exits; bounce-reject returns leave them alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_state      <= IDLE_LOW;
            button_db      <= 1'b0;
            button_press   <= 1'b0;
            button_release <= 1'b0;
        end else begin
            fsm_state      <= next_state;
            button_press   <= 1'b0;
            button_release <= 1'b0;
            if (fsm_state == CHECK_HIGH && next_state == IDLE_HIGH) begin
                button_db    <= 1'b1;
                button_press <= 1'b1;
            end
            if (fsm_state == CHECK_LOW && next_state == IDLE_LOW) begin
                button_db      <= 1'b0;
                button_release <= 1'b1;
            end
        end
    end

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        next_state     = fsm_state;
        state          = 1'b0;
        count_finished = 1'b1;
        unique case (fsm_state)
            IDLE_LOW: begin
                if (sync_in) next_state = CHECK_HIGH;
            end
            CHECK_HIGH: begin
                state          = 1'b1;
                count_finished = 1'b0;
                // Revert is tested first so it wins over a simultaneous threshold hit.
                if (!sync_in) begin
                    next_state     = IDLE_LOW;
                    count_finished = 1'b1;
                end else if (time_counter >= THRESHOLD) begin
                    next_state     = IDLE_HIGH;
                    count_finished = 1'b1;
                end
            end
            IDLE_HIGH: begin
                if (!sync_in) next_state = CHECK_LOW;
            end
            CHECK_LOW: begin
                state          = 1'b1;
                count_finished = 1'b0;
                if (sync_in) begin
                    next_state     = IDLE_HIGH;
                    count_finished = 1'b1;
                end else if (time_counter >= THRESHOLD) begin
                    next_state     = IDLE_LOW;
                    count_finished = 1'b1;
                end
            end
            default: next_state = IDLE_LOW;
        endcase
    end

endmodule

// File: tb/tb_debounce_fsm.sv
// Scoreboard bench for debounce_fsm with a behavioural time-counter stage;
// expected pulses are queued by the stimulus and popped by a pulse monitor.
module tb_debounce_fsm;
    import debounce_pkg::*;

    localparam int CNT_W       = 6;
    localparam int STABLE_CNT  = 4;
    localparam int SYNC_STAGES = 2;
    localparam int LAT         = SYNC_STAGES + 1 + STABLE_CNT;

    typedef enum int {EV_PRESS = 0, EV_RELEASE = 1} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       cyc;
    } ev_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             button_raw;
    logic [CNT_W-1:0] time_counter;
    logic             state;
    logic             count_finished;
    logic             button_db;
    logic             button_press;
    logic             button_release;

    ev_t exp_q[$];
    ev_t mon_e;
    int  cyc    = 0;
    int  checks = 0;
    int  errors = 0;
    int  t0;

    always #5 clk = ~clk;

    debounce_fsm #(
        .CNT_W      (CNT_W),
        .STABLE_CNT (STABLE_CNT),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .button_raw    (button_raw),
        .time_counter  (time_counter),
        .state         (state),
        .count_finished(count_finished),
        .button_db     (button_db),
        .button_press  (button_press),
        .button_release(button_release)
    );

    // Time-counter stage: clear has priority over enable.
    always @(posedge clk or posedge reset) begin
        if (reset)               time_counter <= '0;
        else if (count_finished) time_counter <= '0;
        else if (state)          time_counter <= time_counter + 1'b1;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_pulse(input ev_kind_t kind, input int at);
        ev_t e;
        e.kind = kind;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!reset && (button_press || button_release)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {button_press, button_release}, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("pulse_kind", button_press ? EV_PRESS : EV_RELEASE, mon_e.kind);
                check("pulse_cycle", cyc, mon_e.cyc);
                check("pulse_level", button_db, (mon_e.kind == EV_PRESS) ? 1 : 0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset      = 1'b1;
        button_raw = 1'b0;
        step(2);
        check("reset_state", state, 0);
        check("reset_count_finished", count_finished, 1);
        check("reset_db", button_db, 0);
        check("reset_pulses", {button_press, button_release}, 0);
        reset = 1'b0;
        step(3);

        // 1. Clean press
        t0 = cyc;
        button_raw = 1'b1;
        expect_pulse(EV_PRESS, t0 + LAT);
        step(LAT - 1);
        check("press_db_early", button_db, 0);
        step(1);
        check("press_db_rise", button_db, 1);
        step(13);
        check("idle_high_state", state, 0);
        check("idle_high_cf", count_finished, 1);

        // 3. Release
        t0 = cyc;
        button_raw = 1'b0;
        expect_pulse(EV_RELEASE, t0 + LAT);
        step(LAT - 1);
        check("release_db_early", button_db, 1);
        step(1);
        check("release_db_fall", button_db, 0);
        step(8);

        // 2. Bounce: high 2, low 1, then high
        t0 = cyc;
        button_raw = 1'b1;
        step(2);
        button_raw = 1'b0;
        step(1);
        button_raw = 1'b1;
        expect_pulse(EV_PRESS, t0 + 3 + LAT);
        step(1);
        check("bounce_exit_state", state, 1);
        check("bounce_exit_cf", count_finished, 1);
        step(1);
        check("bounce_idle_state", state, 0);
        check("bounce_idle_counter", time_counter, 0);
        step(4);
        check("bounce_db_early", button_db, 0);
        step(1);
        check("bounce_db_rise", button_db, 1);
        step(8);

        // 4. Glitch low for 3 cycles while high
        t0 = cyc;
        button_raw = 1'b0;
        step(3);
        button_raw = 1'b1;
        step(2);
        check("glitch_counter", time_counter, 2);
        check("glitch_exit_cf", count_finished, 1);
        step(1);
        check("glitch_counter_clear", time_counter, 0);
        check("glitch_state", state, 0);
        check("glitch_db", button_db, 1);
        step(8);

        // 6. Threshold and revert in the same cycle
        button_raw = 1'b0;
        step(4);
        button_raw = 1'b1;
        step(2);
        check("tie_counter", time_counter, STABLE_CNT - 1);
        check("tie_state", state, 1);
        check("tie_cf", count_finished, 1);
        step(1);
        check("tie_idle_state", state, 0);
        check("tie_db", button_db, 1);
        check("tie_counter_clear", time_counter, 0);
        step(8);

        // Return to low before the reset test
        t0 = cyc;
        button_raw = 1'b0;
        expect_pulse(EV_RELEASE, t0 + LAT);
        step(12);

        // 5. Reset in CHECK_HIGH with counter at 2
        button_raw = 1'b1;
        step(5);
        check("pre_reset_counter", time_counter, 2);
        check("pre_reset_state", state, 1);
        reset = 1'b1;
        #1;
        check("mid_reset_state", state, 0);
        check("mid_reset_cf", count_finished, 1);
        check("mid_reset_db", button_db, 0);
        check("mid_reset_counter", time_counter, 0);
        button_raw = 1'b0;
        step(2);
        reset = 1'b0;
        step(4);
        check("post_reset_db", button_db, 0);

        t0 = cyc;
        button_raw = 1'b1;
        expect_pulse(EV_PRESS, t0 + LAT);
        step(12);
        check("post_reset_press_db", button_db, 1);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
